// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a K x N weight-stationary systolic MAC array: clear, load weight
// rows, stream skewed input lanes, and flag per-column result captures.
module systolic_seq_ctrl #(
   parameter int M     = 5,
   parameter int N     = 3,
   parameter int K     = 4,
   parameter int CNT_W = 5,
   parameter int KW    = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             array_clr,
   output logic             w_load_en,
   output logic [KW-1:0]    w_load_row,
   output logic [K-1:0]     x_lane_en,
   output logic [CNT_W-1:0] x_t,
   output logic [N-1:0]     y_col_en
);

   localparam int T_LAST = M + N + K - 2;
   localparam logic [CNT_W-1:0] T_LAST_C   = CNT_W'(T_LAST);
   localparam logic [KW-1:0]    ROW_LAST_C = KW'(K - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLR    = 3'd1,
      S_LOAD   = 3'd2,
      S_STREAM = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [KW-1:0]    r_row;
   logic [KW-1:0]    w_row_next;
   logic [CNT_W-1:0] r_t;
   logic [CNT_W-1:0] w_t_next;

   // One extra bit so window ends up to T_LAST+1 never alias to zero.
   logic [CNT_W:0]   w_t_ext;
   logic [K-1:0]     w_x_win;
   logic [N-1:0]     w_y_win;

   assign w_t_ext = {1'b0, r_t};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_row   <= '0;
         r_t     <= '0;
      end else begin
         r_state <= w_state_next;
         r_row   <= w_row_next;
         r_t     <= w_t_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_row_next   = r_row;
      w_t_next     = r_t;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_CLR;
               w_row_next   = '0;
               w_t_next     = '0;
            end
         end
         S_CLR: begin
            w_state_next = S_LOAD;
            w_row_next   = '0;
            w_t_next     = '0;
         end
         S_LOAD: begin
            if (r_row == ROW_LAST_C) begin
               w_state_next = S_STREAM;
               w_row_next   = '0;
               w_t_next     = '0;
            end else begin
               w_row_next = r_row + 1'b1;
            end
         end
         S_STREAM: begin
            if (r_t == T_LAST_C) begin
               w_state_next = S_DONE;
               w_t_next     = '0;
            end else begin
               w_t_next = r_t + 1'b1;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
            w_row_next   = '0;
            w_t_next     = '0;
         end
         default: begin
            w_state_next = S_IDLE;
            w_row_next   = '0;
            w_t_next     = '0;
         end
      endcase
      if (abort && (r_state != S_IDLE)) begin
         w_state_next = S_IDLE;
         w_row_next   = '0;
         w_t_next     = '0;
      end
   end

   // Window test as (t - lo) < M: a t below lo wraps to a huge value and fails.
   genvar gi;
   generate
      for (gi = 0; gi < K; gi++) begin : g_x_win
         localparam logic [CNT_W:0] X_LO = (CNT_W + 1)'(gi);
         assign w_x_win[gi] = ((w_t_ext - X_LO) < (CNT_W + 1)'(M));
      end
      for (gi = 0; gi < N; gi++) begin : g_y_win
         localparam logic [CNT_W:0] Y_LO = (CNT_W + 1)'(K + gi);
         assign w_y_win[gi] = ((w_t_ext - Y_LO) < (CNT_W + 1)'(M));
      end
   endgenerate

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      array_clr  = 1'b0;
      w_load_en  = 1'b0;
      w_load_row = '0;
      x_lane_en  = '0;
      x_t        = '0;
      y_col_en   = '0;
      case (r_state)
         S_CLR: begin
            busy      = 1'b1;
            array_clr = 1'b1;
         end
         S_LOAD: begin
            busy       = 1'b1;
            w_load_en  = 1'b1;
            w_load_row = r_row;
         end
         S_STREAM: begin
            busy      = 1'b1;
            x_t       = r_t;
            x_lane_en = w_x_win;
            y_col_en  = w_y_win;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
